mirror_skolem_checker: RTL and testbench

- Exhaustive checker wrapped around the mirror Skolem stage.
- Upstream role: enumerates all 2^N input assignments and drives them to the combinational SKOLEMFORMULA inputs (i0..).
- Downstream role: samples the Skolem outputs (i10..) and checks the mirror specification y == x for every assignment.
- Reports pass/fail, mismatch count and the first counterexample; used as the on-chip/sim acceptance stage for generated Skolem netlists.

---
 rtl/mirror_skolem_checker_pkg.sv | 17 +
 rtl/mirror_skolem_checker_assign_enum.sv | 38 +++
 rtl/mirror_skolem_checker.sv | 160 ++++++++++++++++
 tb/tb_mirror_skolem_checker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mirror_skolem_checker_pkg.sv
// Shared types and sizing helpers for the mirror Skolem checker.
package skolem_chk_pkg;

  // Checker FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  // Counter width needed to hold the value 2^n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/mirror_skolem_checker_assign_enum.sv
// N-bit assignment enumerator: clears to 0, counts up when enabled, flags 2^N-1.
module assign_enum #(
  parameter int unsigned N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] cnt,
  output logic         last_c
);

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + N'(1);
    end
  end

  // Enumerator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign last_c = (cnt_q == {N{1'b1}});

endmodule

// File: rtl/mirror_skolem_checker.sv
// Exhaustive checker: enumerates every input assignment, samples the Skolem
// outputs one stage later and checks y == x, reporting counts and the first
// counterexample.
module mirror_skolem_checker
  import skolem_chk_pkg::*;
#(
  parameter int unsigned N  = 10,
  parameter int unsigned CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [N-1:0]  x_out,
  input  logic [N-1:0]  y_in,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] fail_count,
  output logic [CW-1:0] cnt_total,
  output logic          cex_valid,
  output logic [N-1:0]  cex_x,
  output logic [N-1:0]  cex_y
);

  chk_state_t    state_q, state_d;
  logic          valid_q, valid_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;
  logic [CW-1:0] fail_q, fail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cexv_q, cexv_d;
  logic [N-1:0]  cex_x_q, cex_x_d;
  logic [N-1:0]  cex_y_q, cex_y_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic          enum_clr;
  logic          enum_en;
  logic          enum_last_c;
  logic [N-1:0]  enum_val;

  assign_enum #(.N(N)) u_enum (
    .clk    (clk),
    .rst    (rst),
    .clr    (enum_clr),
    .en     (enum_en),
    .cnt    (enum_val),
    .last_c (enum_last_c)
  );

  // Next state, pipeline capture, compare/retire and result bookkeeping.
  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    fail_d   = fail_q;
    cnt_d    = cnt_q;
    cexv_d   = cexv_q;
    cex_x_d  = cex_x_q;
    cex_y_d  = cex_y_q;
    enum_clr = 1'b0;
    enum_en  = 1'b0;

    // Retire the registered slot; an abort only drops the slot being captured.
    if (valid_q) begin
      cnt_d = cnt_q + CW'(1);
      if (y_q != x_q) begin
        fail_d = fail_q + CW'(1);
        if (!cexv_q) begin
          cexv_d  = 1'b1;
          cex_x_d = x_q;
          cex_y_d = y_q;
        end
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          enum_clr = 1'b1;
          fail_d   = '0;
          cnt_d    = '0;
          cexv_d   = 1'b0;
          cex_x_d  = '0;
          cex_y_d  = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
          x_d     = enum_val;
          y_d     = y_in;
          if (enum_last_c) begin
            state_d = DRAIN;
          end else begin
            enum_en = 1'b1;
          end
        end
      end
      DRAIN: begin
        state_d = abort ? IDLE : DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = done_d && (fail_d == '0);
  end

  // State, pipeline stage and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fail_q  <= '0;
      cnt_q   <= '0;
      cexv_q  <= 1'b0;
      cex_x_q <= '0;
      cex_y_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      cexv_q  <= cexv_d;
      cex_x_q <= cex_x_d;
      cex_y_q <= cex_y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign x_out      = enum_val;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_q;
  assign cnt_total  = cnt_q;
  assign cex_valid  = cexv_q;
  assign cex_x      = cex_x_q;
  assign cex_y      = cex_y_q;

endmodule

// File: tb/tb_mirror_skolem_checker.sv
// Bench for mirror_skolem_checker: table of full-run scenarios plus
// hand-written abort, mid-run reset and N=2 sequences.
module tb_mirror_skolem_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [9:0]  x_out;
  logic [9:0]  y_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [10:0] fail_count;
  logic [10:0] cnt_total;
  logic        cex_valid;
  logic [9:0]  cex_x;
  logic [9:0]  cex_y;

  logic        start2;
  logic        abort2;
  logic [1:0]  x_out2;
  logic [1:0]  y_in2;
  logic        busy2;
  logic        done2;
  logic        pass2;
  logic [2:0]  fail_count2;
  logic [2:0]  cnt_total2;
  logic        cex_valid2;
  logic [1:0]  cex_x2;
  logic [1:0]  cex_y2;

  int mode;
  int total;
  int passed;

  typedef struct {
    int unsigned fail;
    int unsigned cnt;
    int unsigned pass;
    int unsigned cexv;
    int unsigned cx;
    int unsigned cy;
    int unsigned done_cyc;
    int unsigned busy_cyc;
  } exp_t;

  typedef struct {
    string name;
    int    mode;
    exp_t  e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[3];

  mirror_skolem_checker #(.N(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .x_out      (x_out),
    .y_in       (y_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .cnt_total  (cnt_total),
    .cex_valid  (cex_valid),
    .cex_x      (cex_x),
    .cex_y      (cex_y)
  );

  mirror_skolem_checker #(.N(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .start      (start2),
    .abort      (abort2),
    .x_out      (x_out2),
    .y_in       (y_in2),
    .busy       (busy2),
    .done       (done2),
    .pass       (pass2),
    .fail_count (fail_count2),
    .cnt_total  (cnt_total2),
    .cex_valid  (cex_valid2),
    .cex_x      (cex_x2),
    .cex_y      (cex_y2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Skolem models: 0 correct mirror, 1 bit 3 inverted, 2 zero only at 0x2A5.
  always_comb begin
    case (mode)
      1:       y_in = x_out ^ 10'h008;
      2:       y_in = (x_out == 10'h2A5) ? 10'h000 : x_out;
      default: y_in = x_out;
    endcase
  end

  assign y_in2  = ~x_out2;
  assign abort2 = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      passed++;
    end
  endtask

  function automatic exp_t mk(input int unsigned f, input int unsigned c, input int unsigned p,
                              input int unsigned v, input int unsigned cx, input int unsigned cy,
                              input int unsigned dc, input int unsigned bc);
    exp_t e;
    e.fail = f; e.cnt = c; e.pass = p; e.cexv = v;
    e.cx = cx; e.cy = cy; e.done_cyc = dc; e.busy_cyc = bc;
    return e;
  endfunction

  // Pulse start, run to done (bounded), then pop and compare the expected record.
  task automatic run_check(input string tag, input exp_t e, input bit extra, input bit abort_too);
    exp_t got;
    int unsigned cyc;
    int unsigned busy_n;
    sb.push_back(e);
    start = 1'b1;
    abort = abort_too;
    @(posedge clk); #1;
    start  = 1'b0;
    abort  = 1'b0;
    cyc    = 1;
    busy_n = 0;
    while (!done && cyc < 3000) begin
      if (busy) busy_n++;
      start = extra && (cyc == 10 || cyc == 500 || cyc == 1025);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    got = sb.pop_front();
    chk({tag, " done_cycle"}, cyc, got.done_cyc);
    chk({tag, " busy_cycles"}, busy_n, got.busy_cyc);
    chk({tag, " pass"}, 32'(pass), got.pass);
    chk({tag, " fail_count"}, 32'(fail_count), got.fail);
    chk({tag, " cnt_total"}, 32'(cnt_total), got.cnt);
    chk({tag, " cex_valid"}, 32'(cex_valid), got.cexv);
    chk({tag, " cex_x"}, 32'(cex_x), got.cx);
    chk({tag, " cex_y"}, 32'(cex_y), got.cy);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " x_out"}, 32'(x_out), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " pass"}, 32'(pass), 0);
    chk({tag, " fail_count"}, 32'(fail_count), 0);
    chk({tag, " cnt_total"}, 32'(cnt_total), 0);
    chk({tag, " cex_valid"}, 32'(cex_valid), 0);
    chk({tag, " cex_x"}, 32'(cex_x), 0);
    chk({tag, " cex_y"}, 32'(cex_y), 0);
  endtask

  initial begin
    exp_t good;
    int unsigned cyc;
    total  = 0;
    passed = 0;
    mode   = 0;
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;

    good   = mk(0, 1024, 1, 0, 0, 0, 1026, 1025);
    tbl[0] = '{name: "mirror", mode: 0, e: good};
    tbl[1] = '{name: "bit3_inv", mode: 1, e: mk(1024, 1024, 0, 1, 10'h000, 10'h008, 1026, 1025)};
    tbl[2] = '{name: "zero_at_2a5", mode: 2, e: mk(1, 1024, 0, 1, 10'h2A5, 10'h000, 1026, 1025)};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("reset");

    // Full-run scenarios; later ones start from DONE of the previous one.
    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].mode;
      run_check(tbl[i].name, tbl[i].e, 1'b0, 1'b0);
    end

    // Abort while x_out == 500.
    mode  = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 0;
    while (x_out != 10'd500 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort reach_500", 32'(x_out), 500);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort cnt_total", 32'(cnt_total), 500);
    chk("abort fail_count", 32'(fail_count), 0);
    chk("abort x_out_hold", 32'(x_out), 500);
    repeat (3) @(posedge clk);
    #1;
    chk("abort frozen cnt_total", 32'(cnt_total), 500);
    chk("abort frozen busy", 32'(busy), 0);
    // start with abort in IDLE: start wins.
    run_check("restart_after_abort", good, 1'b0, 1'b1);

    // Reset mid-run with a failing model, then a clean run with stray starts.
    mode  = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("midrun fail_nonzero", 32'(fail_count != 0), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals("midrun_rst");
    mode = 0;
    run_check("post_rst_extra_starts", good, 1'b1, 1'b0);

    // N=2 instance with y = ~x.
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc    = 1;
    while (!done2 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("n2 done_cycle", cyc, 6);
    chk("n2 fail_count", 32'(fail_count2), 4);
    chk("n2 cnt_total", 32'(cnt_total2), 4);
    chk("n2 pass", 32'(pass2), 0);
    chk("n2 cex_valid", 32'(cex_valid2), 1);
    chk("n2 cex_x", 32'(cex_x2), 0);
    chk("n2 cex_y", 32'(cex_y2), 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
